// File: rtl/fir_stream_driver.sv
// Drives the FIR strobe/idle sample interface from a valid/ready FIFO and
// captures FIR results into a valid/ready register. Define FIR_DRV_GAP_EN to add a GAP_CYCLES hold-off between issues.
module fir_stream_driver #(
  parameter int WIDTH_IN   = 16,
  parameter int WIDTH_OUT  = 16,
  parameter int FIFO_AW    = 3,
  parameter int GAP_CYCLES = 15
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic signed [WIDTH_IN-1:0]  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic signed [WIDTH_IN-1:0]  fir_dataIn,
  output logic                        fir_strobe_dataIn,
  input  logic                        fir_idle,
  input  logic                        fir_strobe_dataOut,
  input  logic signed [WIDTH_OUT-1:0] fir_dataOut,
  output logic signed [WIDTH_OUT-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [FIFO_AW:0]            fifo_level,
  output logic                        ovf_sticky
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

`ifdef FIR_DRV_GAP_EN
  typedef enum logic [1:0] {IDLE, BLANK, BUSY, GAP} state_t;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GAP_W-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, BLANK, BUSY} state_t;
`endif

  state_t state, state_nxt;

  logic signed [WIDTH_IN-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]         wr_ptr;
  logic [FIFO_AW-1:0]         rd_ptr;
  logic [FIFO_AW:0]           level_nxt;
  logic                       push;
  logic                       pop;

  // s_ready already reflects a full FIFO, so a pop on the same edge never
  // opens room for a push.
  assign push = s_valid && s_ready;

  always_comb begin
    level_nxt = fifo_level;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + 1'b1;
      2'b01:   level_nxt = fifo_level - 1'b1;
      default: level_nxt = fifo_level;
    endcase
  end

  // Issue FSM: BLANK ignores fir_idle so a late-dropping idle is tolerated.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0 && fir_idle) begin
          pop       = 1'b1;
          state_nxt = BLANK;
        end
      end
      BLANK: state_nxt = BUSY;
      BUSY: begin
        if (fir_idle) begin
`ifdef FIR_DRV_GAP_EN
          state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef FIR_DRV_GAP_EN
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_level        <= '0;
      s_ready           <= 1'b0;
      fir_strobe_dataIn <= 1'b0;
      fir_dataIn        <= '0;
    end else begin
      state             <= state_nxt;
      fifo_level        <= level_nxt;
      s_ready           <= (level_nxt < DEPTH_L);
      fir_strobe_dataIn <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        fir_dataIn <= mem[rd_ptr];
      end
    end
  end

`ifdef FIR_DRV_GAP_EN
  // Loaded with GAP_CYCLES-1 so GAP lasts exactly GAP_CYCLES cycles.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gap_cnt <= '0;
    end else if (state == BUSY && fir_idle) begin
      gap_cnt <= GAP_W'(GAP_CYCLES - 1);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
`endif

  // Result capture runs regardless of the issue FSM state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (fir_strobe_dataOut) begin
      if (!m_valid || m_ready) begin
        m_data  <= fir_dataOut;
        m_valid <= 1'b1;
      end else begin
        ovf_sticky <= 1'b1;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Hardware initiator for the FIR unit's strobe/idle sample interface.
- Accepts input samples from a valid/ready stream into a small FIFO.
- Issues each sample to the FIR as a single-cycle strobe_dataIn, but only while the FIR reports idle.
- Captures each strobe_dataOut result into a valid/ready output register, so the polyphase filter can run in-system without the testbench streaming loop.

Parameters:
- WIDTH_IN, 16: sample width to the FIR (signed).
- WIDTH_OUT, 16: result width from the FIR (signed).
- FIFO_AW, 3: input FIFO address width; depth = 2**FIFO_AW.
- GAP_CYCLES, 15: minimum idle cycles inserted between issues (used only with the optional feature).

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_in  in  1  synchronous, active-high reset
- s_data  in  WIDTH_IN  upstream sample
- s_valid  in  1  upstream sample valid
- s_ready  out  1  FIFO can accept a sample
- fir_dataIn  out  WIDTH_IN  sample to the FIR, held stable between issues
- fir_strobe_dataIn  out  1  one-cycle "input data ready" pulse to the FIR
- fir_idle  in  1  FIR ready for new data
- fir_strobe_dataOut  in  1  FIR result valid, one cycle
- fir_dataOut  in  WIDTH_OUT  FIR result
- m_data  out  WIDTH_OUT  captured result
- m_valid  out  1  captured result valid
- m_ready  in  1  downstream accepts m_data
- fifo_level  out  FIFO_AW+1  samples currently queued
- ovf_sticky  out  1  a FIR result was dropped

Behaviour:
- Reset values (all registered): s_ready=0 during reset and 1 after; fir_dataIn=0; fir_strobe_dataIn=0; m_data=0; m_valid=0; fifo_level=0; ovf_sticky=0; FSM=IDLE.
- FIFO:
  - Push when s_valid && s_ready. s_ready = (fifo_level < depth), registered-level based.
  - When full, no push occurs even if a pop happens on the same edge.
  - A simultaneous push and pop with level between 1 and depth-1 leaves the level unchanged.
  - Pointers wrap modulo depth. Order is strictly FIFO.
- FSM states:
  - IDLE: if fifo_level!=0 && fir_idle, then on the next edge: fir_dataIn<=head, fir_strobe_dataIn<=1, pop, go to BLANK. Otherwise stay.
  - BLANK: one cycle. fir_strobe_dataIn<=0. fir_idle is ignored here, which tolerates an FIR that deasserts idle one cycle late. Go to BUSY.
  - BUSY: wait until fir_idle==1, then go to GAP (feature on) or IDLE (feature off).
  - GAP: count down GAP_CYCLES cycles, then go to IDLE.
- Latency and pulse rules:
  - A sample pushed on edge t into an empty FIFO with fir_idle=1 produces fir_strobe_dataIn high from edge t+1 to edge t+2.
  - fir_strobe_dataIn is never high for two consecutive cycles.
  - There is exactly one strobe per popped sample.
- Output capture:
  - On fir_strobe_dataOut: if !m_valid || m_ready, then m_data<=fir_dataOut and m_valid<=1.
  - Otherwise the new result is dropped and ovf_sticky<=1.
  - A handshake (m_valid && m_ready) with no new strobe clears m_valid.
  - ovf_sticky clears only on reset.
- Output capture is independent of the issue FSM; results may arrive in any state.
- Widths: data passes through unchanged, with no arithmetic or sign extension.
- Reset mid-operation: the FIFO is flushed, the FSM returns to IDLE, any strobe in flight is cut, and a pending result is discarded. The FIR must be reset concurrently by the system.

Optional Feature:
- Macro FIR_DRV_GAP_EN.
- Defined: after BUSY sees fir_idle=1, the FSM holds in GAP for exactly GAP_CYCLES cycles before IDLE. Consecutive strobe rising edges are therefore at least GAP_CYCLES+3 cycles apart. This separates cycles in waveform display and throttles the FIR.
- Undefined: the GAP state and its counter are absent, and BUSY goes directly to IDLE.

Test Plan:
- Stub FIR (idle drops on the cycle after strobe, returns 4 cycles later, then emits strobe_dataOut with dataIn*2), push 100, -5, 1000 → three strobes with fir_dataIn 100, -5, 1000 in order; m_data 200, -10, 2000; ovf_sticky=0.
- Hold fir_idle=0, push 9 samples continuously → s_ready=0 after the 8th accepted; fifo_level=8; 9th not taken. Then raise fir_idle → 8 strobes in push order, fifo_level reaches 0.
- m_ready=0, strobe_dataOut with 7 then 9 → m_data=7, ovf_sticky=1. Then m_ready=1 on the same cycle as strobe_dataOut 11 → m_data=11, m_valid stays 1.
- Assert rst_in for one cycle while in BLANK with 3 samples queued and m_valid=1 → next cycle fifo_level=0, fir_strobe_dataIn=0, m_valid=0, ovf_sticky=0, FSM IDLE.
- Stub keeps fir_idle=1 permanently → one strobe per sample, consecutive strobes 3 cycles apart (feature off); with FIR_DRV_GAP_EN and GAP_CYCLES=15 → 18 cycles apart.
- Push into an empty FIFO on the same edge that the previous sample is popped → both samples issued, none lost or duplicated; fifo_level never exceeds 1.
